// File: rtl/pipe_pwr_pkg.sv
// Shared types and defaults for the pipeline power sequencer.
//   pwr_state_e       : 4-bit FSM state encoding, also exported on the state port
//   DEF_*             : default values for the sequencer timing parameters
//   cnt_width/load_of : sizing helpers for the shared state timer
package pipe_pwr_pkg;

  typedef enum logic [3:0] {
    ST_ON       = 4'd0,
    ST_DRAIN    = 4'd1,
    ST_ISOLATE  = 4'd2,
    ST_SAVE     = 4'd3,
    ST_PWR_DOWN = 4'd4,
    ST_OFF      = 4'd5,
    ST_PWR_UP   = 4'd6,
    ST_RESTORE  = 4'd7,
    ST_DEISO    = 4'd8
  } pwr_state_e;

  localparam int unsigned DEF_DRAIN_CYCLES  = 4;
  localparam int unsigned DEF_SETTLE_CYCLES = 2;
  localparam int unsigned DEF_PG_TIMEOUT    = 16;

  // Bits needed to hold max_val (at least one).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = 1;
    while ((max_val >> w) != 0) w++;
    return w;
  endfunction

  // The timer counts down to zero inclusive, so an N-cycle wait loads N-1.
  function automatic int unsigned load_of(input int unsigned cycles);
    return (cycles == 0) ? 0 : cycles - 1;
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Loadable saturating down-counter used to time each sequencer state.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears the count)
//   load_i        : load load_val_i this cycle (takes priority over counting)
//   load_val_i    : value to load
//   done_o        : count has reached zero; the count then holds at zero
module pwr_seq_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pipe_pwr_seq.sv
// Power sequencer for a pipeline power domain: drain, isolate, retention
// save, switch off; and on wake: switch on, retention restore, de-isolate.
//   clk, rst_n      : clock, asynchronous active-low reset
//   sleep_req       : level request to power the domain down
//   wake_req        : level request to power the domain up
//   pipe_busy       : some pipeline stage still holds valid data
//   pwr_good        : power switch status
//   err_clr         : clears err_timeout
//   pipe_stall      : freezes pipeline input acceptance
//   iso_en          : clamps domain outputs
//   ret_save        : one-cycle retention save pulse
//   ret_restore     : one-cycle retention restore pulse
//   pwr_en          : power switch enable
//   sleep_ack       : domain is off
//   err_timeout     : sticky pwr_good timeout flag
//   state           : current FSM state
module pipe_pwr_seq
  import pipe_pwr_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES  = DEF_DRAIN_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned PG_TIMEOUT    = DEF_PG_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       pipe_busy,
  input  logic       pwr_good,
  input  logic       err_clr,
  output logic       pipe_stall,
  output logic       iso_en,
  output logic       ret_save,
  output logic       ret_restore,
  output logic       pwr_en,
  output logic       sleep_ack,
  output logic       err_timeout,
  output logic [3:0] state
);

  localparam int unsigned MAX_LOAD_A = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MAX_LOAD   = (MAX_LOAD_A > PG_TIMEOUT) ? MAX_LOAD_A : PG_TIMEOUT;
  localparam int unsigned CNT_W      = cnt_width(MAX_LOAD);

  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(load_of(DRAIN_CYCLES));
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(load_of(SETTLE_CYCLES));
  localparam logic [CNT_W-1:0] PG_LD     = CNT_W'(load_of(PG_TIMEOUT));

  pwr_state_e       state_q, state_d;
  logic             err_q, err_d, err_set;
  logic             tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;

  logic stall_q, stall_d;
  logic iso_q, iso_d;
  logic save_q, save_d;
  logic restore_q, restore_d;
  logic pwr_en_q, pwr_en_d;
  logic ack_q, ack_d;

  // Next state and timeout detection.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    case (state_q)
      ST_ON: begin
        if (sleep_req && !wake_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wake_req) begin
          state_d = ST_ON;
        end else if (tmr_done && !pipe_busy) begin
          state_d = ST_ISOLATE;
        end
      end
      ST_ISOLATE: begin
        if (tmr_done) state_d = ST_SAVE;
      end
      ST_SAVE: begin
        state_d = ST_PWR_DOWN;
      end
      ST_PWR_DOWN: begin
        if (!pwr_good) begin
          state_d = ST_OFF;
        end else if (tmr_done) begin
          state_d = ST_OFF;
          err_set = 1'b1;
        end
      end
      ST_OFF: begin
        if (wake_req) state_d = ST_PWR_UP;
      end
      ST_PWR_UP: begin
        // Keep waiting after a timeout; the saturated timer keeps err set.
        if (pwr_good) begin
          state_d = ST_RESTORE;
        end else if (tmr_done) begin
          err_set = 1'b1;
        end
      end
      ST_RESTORE: begin
        state_d = ST_DEISO;
      end
      ST_DEISO: begin
        if (tmr_done) state_d = ST_ON;
      end
      default: begin
        state_d = ST_ON;
      end
    endcase
  end

  // Timer is reloaded for the state being entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      ST_DRAIN:                tmr_val = DRAIN_LD;
      ST_ISOLATE, ST_DEISO:    tmr_val = SETTLE_LD;
      ST_PWR_DOWN, ST_PWR_UP:  tmr_val = PG_LD;
      default:                 tmr_val = '0;
    endcase
  end

  assign err_d = err_set | (err_q & ~err_clr);

  // Outputs are decoded from the next state so the registered outputs
  // line up with the registered state.
  always_comb begin
    stall_d   = 1'b1;
    iso_d     = 1'b1;
    save_d    = 1'b0;
    restore_d = 1'b0;
    pwr_en_d  = 1'b1;
    ack_d     = 1'b0;
    case (state_d)
      ST_ON: begin
        stall_d = 1'b0;
        iso_d   = 1'b0;
      end
      ST_DRAIN:    iso_d     = 1'b0;
      ST_SAVE:     save_d    = 1'b1;
      ST_PWR_DOWN: pwr_en_d  = 1'b0;
      ST_OFF: begin
        pwr_en_d = 1'b0;
        ack_d    = 1'b1;
      end
      ST_RESTORE:  restore_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ON;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
      iso_q     <= 1'b0;
      save_q    <= 1'b0;
      restore_q <= 1'b0;
      pwr_en_q  <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      err_q     <= err_d;
      stall_q   <= stall_d;
      iso_q     <= iso_d;
      save_q    <= save_d;
      restore_q <= restore_d;
      pwr_en_q  <= pwr_en_d;
      ack_q     <= ack_d;
    end
  end

  pwr_seq_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  assign pipe_stall  = stall_q;
  assign iso_en      = iso_q;
  assign ret_save    = save_q;
  assign ret_restore = restore_q;
  assign pwr_en      = pwr_en_q;
  assign sleep_ack   = ack_q;
  assign err_timeout = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pipe_pwr_seq.sv
module tb_pipe_pwr_seq;
  import pipe_pwr_pkg::*;

  localparam int unsigned DRAIN  = 4;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned PGT    = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sleep_req = 1'b0;
  logic       wake_req = 1'b0;
  logic       pipe_busy = 1'b0;
  logic       pwr_good = 1'b1;
  logic       err_clr = 1'b0;
  logic       pipe_stall, iso_en, ret_save, ret_restore, pwr_en, sleep_ack, err_timeout;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: phase plus cycles spent in it (1 on the entry cycle).
  pwr_state_e m_ph = ST_ON;
  int         m_n = 1;
  bit         m_err = 1'b0;

  always #5 clk = ~clk;

  pipe_pwr_seq #(
    .DRAIN_CYCLES (DRAIN),
    .SETTLE_CYCLES(SETTLE),
    .PG_TIMEOUT   (PGT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sleep_req  (sleep_req),
    .wake_req   (wake_req),
    .pipe_busy  (pipe_busy),
    .pwr_good   (pwr_good),
    .err_clr    (err_clr),
    .pipe_stall (pipe_stall),
    .iso_en     (iso_en),
    .ret_save   (ret_save),
    .ret_restore(ret_restore),
    .pwr_en     (pwr_en),
    .sleep_ack  (sleep_ack),
    .err_timeout(err_timeout),
    .state      (state)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // {stall, iso, save, restore, pwr_en, ack} expected in a phase.
  function automatic logic [5:0] exp_out(input pwr_state_e ph);
    logic stall, iso, sv, rs, pe, ack;
    stall = (ph != ST_ON);
    iso   = !(ph inside {ST_ON, ST_DRAIN});
    sv    = (ph == ST_SAVE);
    rs    = (ph == ST_RESTORE);
    pe    = !(ph inside {ST_PWR_DOWN, ST_OFF});
    ack   = (ph == ST_OFF);
    return {stall, iso, sv, rs, pe, ack};
  endfunction

  task automatic model_reset();
    m_ph  = ST_ON;
    m_n   = 1;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    pwr_state_e nxt;
    bit         set;
    nxt = m_ph;
    set = 1'b0;
    case (m_ph)
      ST_ON:       if (sleep_req && !wake_req) nxt = ST_DRAIN;
      ST_DRAIN:    if (wake_req) nxt = ST_ON;
                   else if (m_n >= int'(DRAIN) && !pipe_busy) nxt = ST_ISOLATE;
      ST_ISOLATE:  if (m_n >= int'(SETTLE)) nxt = ST_SAVE;
      ST_SAVE:     nxt = ST_PWR_DOWN;
      ST_PWR_DOWN: if (!pwr_good) nxt = ST_OFF;
                   else if (m_n >= int'(PGT)) begin nxt = ST_OFF; set = 1'b1; end
      ST_OFF:      if (wake_req) nxt = ST_PWR_UP;
      ST_PWR_UP:   if (pwr_good) nxt = ST_RESTORE;
                   else if (m_n >= int'(PGT)) set = 1'b1;
      ST_RESTORE:  nxt = ST_DEISO;
      ST_DEISO:    if (m_n >= int'(SETTLE)) nxt = ST_ON;
      default:     nxt = ST_ON;
    endcase
    m_err = set ? 1'b1 : (err_clr ? 1'b0 : m_err);
    if (nxt != m_ph) begin
      m_ph = nxt;
      m_n  = 1;
    end else if (m_n < 100000) begin
      m_n++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic apply_reset();
    sleep_req = 1'b0;
    wake_req  = 1'b0;
    pipe_busy = 1'b0;
    err_clr   = 1'b0;
    rst_n     = 1'b0;
    model_reset();
    tick();
    tick();
    rst_n    = 1'b1;
    pwr_good = 1'b1;
  endtask

  // Drive a normal sleep from ON until sleep_ack; ok reports success.
  task automatic go_off(output bit ok);
    int g;
    pipe_busy = 1'b0;
    wake_req  = 1'b0;
    pwr_good  = 1'b1;
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    g = 0;
    while (!sleep_ack && g < 60) begin
      if (state == ST_PWR_DOWN) pwr_good = 1'b0;
      tick();
      g++;
    end
    ok = sleep_ack;
  endtask

  task automatic test_reset();
    logic [10:0] obs, exp_v;
    exp_v = {ST_ON, 6'b000010, 1'b0};
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    obs = {state, pipe_stall, iso_en, ret_save, ret_restore, pwr_en, sleep_ack, err_timeout};
    checks++;
    if (obs !== exp_v) $display("FAIL reset_async: got %b expected %b", obs, exp_v);
    if (obs !== exp_v) errors++;
    sleep_req = 1'b1;
    tick();
    tick();
    checks++;
    if (state !== ST_ON || pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: state %0d stall %b expected state 0 stall 0", state, pipe_stall);
    end
    sleep_req = 1'b0;
    rst_n = 1'b1;
    tick();
    obs = {state, pipe_stall, iso_en, ret_save, ret_restore, pwr_en, sleep_ack, err_timeout};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", obs, exp_v);
    end
  endtask

  task automatic test_full_sleep();
    int n, saves, g;
    pipe_busy = 1'b0;
    pwr_good  = 1'b1;
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    checks++;
    if (state !== ST_DRAIN || pipe_stall !== 1'b1 || iso_en !== 1'b0) begin
      errors++;
      $display("FAIL sleep_enter_drain: state %0d stall %b iso %b expected 1 1 0", state, pipe_stall, iso_en);
    end
    n = 0;
    while (state == ST_DRAIN && n < 50) begin
      n++;
      tick();
    end
    checks++;
    if (n != int'(DRAIN)) begin
      errors++;
      $display("FAIL sleep_drain_len: got %0d cycles expected %0d", n, DRAIN);
    end
    checks++;
    if (state !== ST_ISOLATE || iso_en !== 1'b1) begin
      errors++;
      $display("FAIL sleep_isolate: state %0d iso %b expected 2 1", state, iso_en);
    end
    saves = 0;
    g = 0;
    while (state != ST_PWR_DOWN && g < 20) begin
      if (ret_save) saves++;
      tick();
      g++;
    end
    checks++;
    if (saves != 1) begin
      errors++;
      $display("FAIL sleep_save_pulse: got %0d pulses expected 1", saves);
    end
    checks++;
    if (state !== ST_PWR_DOWN || pwr_en !== 1'b0 || iso_en !== 1'b1 || ret_save !== 1'b0) begin
      errors++;
      $display("FAIL sleep_pwr_down: state %0d pwr_en %b iso %b save %b expected 4 0 1 0",
               state, pwr_en, iso_en, ret_save);
    end
    tick();
    tick();
    pwr_good = 1'b0;
    tick();
    checks++;
    if (state !== ST_OFF || sleep_ack !== 1'b1 || pwr_en !== 1'b0 || err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL sleep_off: state %0d ack %b pwr_en %b err %b expected 5 1 0 0",
               state, sleep_ack, pwr_en, err_timeout);
    end
  endtask

  task automatic test_wake();
    int restores, iso_after, g;
    bit seen;
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    checks++;
    if (state !== ST_PWR_UP || pwr_en !== 1'b1 || iso_en !== 1'b1 || sleep_ack !== 1'b0) begin
      errors++;
      $display("FAIL wake_pwr_up: state %0d pwr_en %b iso %b ack %b expected 6 1 1 0",
               state, pwr_en, iso_en, sleep_ack);
    end
    for (int i = 0; i < 4; i++) tick();
    pwr_good  = 1'b1;
    restores  = 0;
    iso_after = 0;
    seen      = 1'b0;
    g         = 0;
    while (state != ST_ON && g < 30) begin
      if (ret_restore) begin
        restores++;
        seen = 1'b1;
      end else if (seen && iso_en) begin
        iso_after++;
      end
      tick();
      g++;
    end
    checks++;
    if (restores != 1) begin
      errors++;
      $display("FAIL wake_restore_pulse: got %0d expected 1", restores);
    end
    checks++;
    if (iso_after != int'(SETTLE)) begin
      errors++;
      $display("FAIL wake_deiso_len: got %0d expected %0d", iso_after, SETTLE);
    end
    checks++;
    if (state !== ST_ON || pipe_stall !== 1'b0 || iso_en !== 1'b0 || pwr_en !== 1'b1) begin
      errors++;
      $display("FAIL wake_on: state %0d stall %b iso %b pwr_en %b expected 0 0 0 1",
               state, pipe_stall, iso_en, pwr_en);
    end
  endtask

  task automatic test_busy_drain();
    int bad;
    pipe_busy = 1'b1;
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (state != ST_DRAIN || iso_en) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_hold: %0d cycles left DRAIN or isolated, expected 0", bad);
    end
    pipe_busy = 1'b0;
    checks++;
    if (state !== ST_DRAIN || iso_en !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall: state %0d iso %b expected 1 0", state, iso_en);
    end
    tick();
    checks++;
    if (state !== ST_ISOLATE || iso_en !== 1'b1) begin
      errors++;
      $display("FAIL busy_isolate: state %0d iso %b expected 2 1", state, iso_en);
    end
  endtask

  task automatic test_abort();
    int iso_seen;
    iso_seen = 0;
    sleep_req = 1'b1;
    wake_req  = 1'b1;
    tick();
    checks++;
    if (state !== ST_ON) begin
      errors++;
      $display("FAIL abort_both_req: state %0d expected 0", state);
    end
    wake_req = 1'b0;
    tick();
    sleep_req = 1'b0;
    if (iso_en) iso_seen++;
    tick();
    if (iso_en) iso_seen++;
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    checks++;
    if (state !== ST_ON || pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL abort_on: state %0d stall %b expected 0 0", state, pipe_stall);
    end
    for (int i = 0; i < 3; i++) begin
      if (iso_en || state != ST_ON) iso_seen++;
      tick();
    end
    checks++;
    if (iso_seen != 0) begin
      errors++;
      $display("FAIL abort_iso: %0d bad cycles expected 0", iso_seen);
    end
  endtask

  task automatic test_pd_timeout();
    int n, g;
    apply_reset();
    pwr_good  = 1'b1;
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    g = 0;
    while (state != ST_PWR_DOWN && g < 30) begin
      tick();
      g++;
    end
    n = 0;
    while (state == ST_PWR_DOWN && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n != int'(PGT)) begin
      errors++;
      $display("FAIL pd_timeout_len: got %0d expected %0d", n, PGT);
    end
    checks++;
    if (state !== ST_OFF || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL pd_timeout_flag: state %0d err %b expected 5 1", state, err_timeout);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0 || state !== ST_OFF) begin
      errors++;
      $display("FAIL pd_timeout_clr: err %b state %0d expected 0 5", err_timeout, state);
    end
  endtask

  task automatic test_timeout();
    int k;
    bit ok;
    apply_reset();
    go_off(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL timeout_setup: sleep_ack %b expected 1", sleep_ack);
    end
    pwr_good = 1'b0;
    wake_req = 1'b1;
    tick();
    wake_req = 1'b0;
    k = 0;
    while (!err_timeout && k < 40) begin
      tick();
      k++;
    end
    checks++;
    if (k != int'(PGT)) begin
      errors++;
      $display("FAIL timeout_len: got %0d cycles expected %0d", k, PGT);
    end
    checks++;
    if (state !== ST_PWR_UP || pwr_en !== 1'b1) begin
      errors++;
      $display("FAIL timeout_wait: state %0d pwr_en %b expected 6 1", state, pwr_en);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_set_prio: err %b expected 1", err_timeout);
    end
    pwr_good = 1'b1;
    tick();
    checks++;
    if (state !== ST_RESTORE || err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: state %0d err %b expected 7 1", state, err_timeout);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: err %b expected 0", err_timeout);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] obs, exp_v;
    int g;
    bit ok;
    exp_v = {ST_ON, 6'b000010, 1'b0};
    apply_reset();
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    g = 0;
    while (state != ST_SAVE && g < 30) begin
      tick();
      g++;
    end
    checks++;
    if (state !== ST_SAVE || ret_save !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_reach_save: state %0d save %b expected 3 1", state, ret_save);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    obs = {state, pipe_stall, iso_en, ret_save, ret_restore, pwr_en, sleep_ack, err_timeout};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rst_in_save: got %b expected %b", obs, exp_v);
    end
    tick();
    rst_n = 1'b1;
    tick();
    go_off(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rst_mid_reach_off: sleep_ack %b expected 1", sleep_ack);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    obs = {state, pipe_stall, iso_en, ret_save, ret_restore, pwr_en, sleep_ack, err_timeout};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rst_in_off: got %b expected %b", obs, exp_v);
    end
    tick();
    rst_n    = 1'b1;
    pwr_good = 1'b1;
    tick();
    checks++;
    if (ret_restore !== 1'b0 || state !== ST_ON) begin
      errors++;
      $display("FAIL rst_off_no_restore: restore %b state %0d expected 0 0", ret_restore, state);
    end
  endtask

  task automatic test_random();
    logic [10:0] obs, exp_v;
    apply_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      sleep_req = ($urandom_range(0, 9) < 3);
      wake_req  = ($urandom_range(0, 9) < 2);
      pipe_busy = ($urandom_range(0, 3) == 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) < 85) pwr_good = pwr_en;
      else pwr_good = 1'($urandom_range(0, 1));
      tick();
      obs   = {state, pipe_stall, iso_en, ret_save, ret_restore, pwr_en, sleep_ack, err_timeout};
      exp_v = {m_ph, exp_out(m_ph), m_err};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random cycle %0d: got %b expected %b", cyc, obs, exp_v);
      end
    end
    sleep_req = 1'b0;
    wake_req  = 1'b0;
    err_clr   = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_sleep();
    test_wake();
    test_busy_drain();
    apply_reset();
    test_abort();
    test_pd_timeout();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_pwr_seq.md
PIPE_PWR_SEQ -- requirements
Module: pipe_pwr_seq

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 4, minimum stall cycles before isolation (pipeline depth plus output register).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 2, cycles of isolation held before save and before isolation release.
REQ-003 SHALL have parameter PG_TIMEOUT, default 16, cycles allowed for pwr_good to follow pwr_en.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port sleep_req, input, 1 bit: level request to power down the pipeline domain.
REQ-007 SHALL have port wake_req, input, 1 bit: level request to power up the pipeline domain.
REQ-008 SHALL have port pipe_busy, input, 1 bit: high while any pipeline stage holds valid data.
REQ-009 SHALL have port pwr_good, input, 1 bit: power-switch status, high when the domain is powered.
REQ-010 SHALL have port err_clr, input, 1 bit: clears err_timeout.
REQ-011 SHALL have port pipe_stall, output, 1 bit: freezes pipeline input acceptance.
REQ-012 SHALL have port iso_en, output, 1 bit: clamps domain outputs.
REQ-013 SHALL have port ret_save, output, 1 bit: one-cycle retention save pulse.
REQ-014 SHALL have port ret_restore, output, 1 bit: one-cycle retention restore pulse.
REQ-015 SHALL have port pwr_en, output, 1 bit: power-switch enable.
REQ-016 SHALL have port sleep_ack, output, 1 bit: high only in state OFF.
REQ-017 SHALL have port err_timeout, output, 1 bit: sticky pwr_good timeout flag.
REQ-018 SHALL have port state, output, 4 bits: current FSM state encoding.

Function
REQ-019 SHALL implement states ON, DRAIN, ISOLATE, SAVE, PWR_DOWN, OFF, PWR_UP, RESTORE, DEISO, all outputs registered.
REQ-020 SHALL, in ON, drive pipe_stall=0, iso_en=0, pwr_en=1, and go to DRAIN when sleep_req=1 and wake_req=0; simultaneous sleep_req and wake_req keep ON.
REQ-021 SHALL, in DRAIN, hold pipe_stall=1, count cycles, and go to ISOLATE once at least DRAIN_CYCLES cycles have elapsed and pipe_busy=0; pipe_busy=1 extends DRAIN indefinitely.
REQ-022 SHALL abort DRAIN to ON when wake_req=1, deasserting pipe_stall on entry to ON.
REQ-023 SHALL, in ISOLATE, assert iso_en for SETTLE_CYCLES cycles, then go to SAVE; sleep or wake requests are ignored from ISOLATE through OFF entry.
REQ-024 SHALL, in SAVE, assert ret_save for exactly one cycle, then go to PWR_DOWN.
REQ-025 SHALL, in PWR_DOWN, drive pwr_en=0 and go to OFF when pwr_good=0, or after PG_TIMEOUT cycles, setting err_timeout.
REQ-026 SHALL, in OFF, keep iso_en=1, pipe_stall=1, pwr_en=0, sleep_ack=1, and go to PWR_UP when wake_req=1.
REQ-027 SHALL, in PWR_UP, drive pwr_en=1 and go to RESTORE when pwr_good=1; after PG_TIMEOUT cycles, set err_timeout and keep waiting.
REQ-028 SHALL, in RESTORE, assert ret_restore for exactly one cycle, then go to DEISO.
REQ-029 SHALL, in DEISO, hold iso_en=1 for SETTLE_CYCLES cycles, then go to ON, releasing iso_en and pipe_stall together.
REQ-030 SHALL reload the shared cycle counter on every state entry, and the counter SHALL saturate, never wrap.
REQ-031 SHALL make err_timeout sticky until err_clr=1; a simultaneous set takes priority over clear.

Reset
REQ-032 SHALL, on rst_n=0, asynchronously force state ON, pipe_stall=0, iso_en=0, ret_save=0, ret_restore=0, pwr_en=1, sleep_ack=0, err_timeout=0, and clear the counter.
REQ-033 SHALL, when reset is asserted mid-sequence (including OFF), return directly to ON with no retention pulse.

Structure
REQ-034 SHALL place the state enum (4 bits) and default parameter constants in package pipe_pwr_pkg.
REQ-035 SHALL use one sub-module, pwr_seq_timer: a loadable saturating down-counter with a done flag.

Verification
REQ-036 SHALL cover a full sleep: with pipe_busy=0, pulse sleep_req; expect ISOLATE after 4 DRAIN cycles, ret_save on one cycle, pwr_en=0; with pwr_good dropping 3 cycles later, sleep_ack=1.
REQ-037 SHALL cover a busy drain: hold pipe_busy=1 for 10 DRAIN cycles; expect iso_en=0 until the cycle after pipe_busy falls.
REQ-038 SHALL cover a wake from OFF: wake_req=1 and pwr_good rising after 5 cycles; expect one ret_restore pulse, iso_en=1 for 2 more cycles, then ON with pipe_stall=0.
REQ-039 SHALL cover an abort: wake_req during DRAIN cycle 2; expect ON next cycle, with iso_en never asserted.
REQ-040 SHALL cover a timeout: hold pwr_good=0 in PWR_UP; expect err_timeout=1 after 16 cycles; err_clr clears it.
REQ-041 SHALL cover reset in SAVE or OFF: expect immediate ON outputs per REQ-032.
